// File: rtl/ce_timer_pkg.sv
// Shared types and arcade-build defaults for the clock-enable / interrupt timer bank.
package ce_timer_pkg;

    localparam int CNT_W_DEF = 16;
    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Divisors for the arcade build (period = divisor + 1 system clocks)
    localparam cnt_t DIV_3MHZ = cnt_t'(7);
    localparam cnt_t DIV_6MHZ = cnt_t'(3);
    localparam cnt_t DIV_3KHZ = cnt_t'(8191);
    localparam cnt_t DIV_6KHZ = cnt_t'(4095);

    localparam int IRQ_PERIOD_DEF = 14;
    localparam int IRQ_AT_DEF     = 12;

    function automatic int irq_cnt_w(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/ce_timer_bank_if.sv
// Control/status bundle between the timer bank and its host: divisor and phase
// programming in, clock-enable strobes, square levels, interrupt and core reset out.
interface ce_timer_bank_if
    import ce_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    logic [NUM_CH-1:0][CNT_W-1:0] div_i;
    logic [NUM_CH-1:0][CNT_W-1:0] phase_i;
    logic [NUM_CH-1:0]            en_i;
    logic                         resync_i;
    logic                         irq_en_i;
    logic [NUM_CH-1:0]            tick_o;
    logic [NUM_CH-1:0]            level_o;
    logic                         irq_o;
    logic                         core_rst_o;

    modport master (
        output div_i, phase_i, en_i, resync_i, irq_en_i,
        input  tick_o, level_o, irq_o, core_rst_o
    );

    modport slave (
        input  div_i, phase_i, en_i, resync_i, irq_en_i,
        output tick_o, level_o, irq_o, core_rst_o
    );
endinterface

// File: rtl/ce_divider.sv
// One divider channel: wrap counter with registered tick strobe and square level.
// term_o is the unregistered terminal event, exposed for same-cycle consumers.
module ce_divider
    import ce_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] phase_i,
    input  logic             en_i,
    input  logic             resync_i,
    output logic             term_o,
    output logic             tick_o,
    output logic             level_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             term;

    always_comb begin
        // >= rather than == so a divisor lowered below the count wraps at once
        term    = !rst && !resync_i && en_i && (cnt_q >= div_i);
        cnt_d   = cnt_q;
        tick_d  = term;
        level_d = (cnt_q > (div_i >> 1));
        if (rst) begin
            cnt_d   = phase_i;
            tick_d  = 1'b0;
            level_d = 1'b0;
        end else if (resync_i) begin
            cnt_d = phase_i;
        end else if (en_i) begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        tick_q  <= tick_d;
        level_q <= level_d;
    end

    assign term_o  = term;
    assign tick_o  = tick_q;
    assign level_o = level_q;

endmodule

// File: rtl/ce_timer_bank.sv
// Bank of NUM_CH clock-enable dividers plus the periodic interrupt counter and
// the core-reset release derived from selected channels.
module ce_timer_bank
    import ce_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int IRQ_SRC    = 2,
    parameter int IRQ_PERIOD = IRQ_PERIOD_DEF,
    parameter int IRQ_AT     = IRQ_AT_DEF,
    parameter int RST_SRC    = 0
) (
    input  logic          clk,
    input  logic          rst,
    ce_timer_bank_if.slave bus
);

    localparam int IRQ_W = irq_cnt_w(IRQ_PERIOD);
    // Channel selects as masks so every divider output feeds real logic
    localparam logic [NUM_CH-1:0] IRQ_SRC_MASK = NUM_CH'(1) << IRQ_SRC;
    localparam logic [NUM_CH-1:0] RST_SRC_MASK = NUM_CH'(1) << RST_SRC;

    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ce_divider #(
            .CNT_W (CNT_W)
        ) u_div (
            .clk      (clk),
            .rst      (rst),
            .div_i    (bus.div_i[c]),
            .phase_i  (bus.phase_i[c]),
            .en_i     (bus.en_i[c]),
            .resync_i (bus.resync_i),
            .term_o   (term[c]),
            .tick_o   (tick[c]),
            .level_o  (level[c])
        );
    end

    logic             irq_src_ev;
    logic             rst_src_tick;
    logic [IRQ_W-1:0] irq_cnt_q, irq_cnt_d;
    logic             irq_q, irq_d;
    logic             core_rst_q, core_rst_d;

    assign irq_src_ev   = |(term & IRQ_SRC_MASK);
    assign rst_src_tick = |(tick & RST_SRC_MASK);

    always_comb begin
        irq_cnt_d  = irq_cnt_q;
        irq_d      = (irq_cnt_q == IRQ_W'(IRQ_AT));
        core_rst_d = core_rst_q;
        if (rst) begin
            irq_cnt_d  = '0;
            irq_d      = 1'b0;
            core_rst_d = 1'b1;
        end else begin
            // Disable wins over a coincident source event
            if (!bus.irq_en_i) begin
                irq_cnt_d = '0;
                irq_d     = 1'b0;
            end else if (irq_src_ev) begin
                irq_cnt_d = (irq_cnt_q == IRQ_W'(IRQ_PERIOD - 1)) ? '0 : irq_cnt_q + IRQ_W'(1);
            end
            if (rst_src_tick) begin
                core_rst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        irq_cnt_q  <= irq_cnt_d;
        irq_q      <= irq_d;
        core_rst_q <= core_rst_d;
    end

    assign bus.tick_o     = tick;
    assign bus.level_o    = level;
    assign bus.irq_o      = irq_q;
    assign bus.core_rst_o = core_rst_q;

endmodule

// File: doc/ce_timer_bank.md
# ce_timer_bank

Parametrised clock-enable and interrupt-timer bank. It replaces the hand-coded fixed dividers, core-reset release and periodic NMI counter of the arcade top level. It generates NUM_CH independently programmable clock-enable strobes and matching square levels from the single system clock. It also derives one periodic interrupt level and a core-reset release from selectable channels. It sits beside the CPU, vector generator and POKEY, feeding their clk_en inputs.

## Interface
Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 16, counter/divisor width per channel.
- IRQ_SRC, 2, channel whose ticks clock the interrupt counter.
- IRQ_PERIOD, 14, interrupt counter modulus in source ticks (2..256).
- IRQ_AT, 12, counter value during which irq_o is high (< IRQ_PERIOD).
- RST_SRC, 0, channel whose first tick releases core_rst_o.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- div_i, in, NUM_CH x CNT_W: per-channel terminal count; period = div_i+1 clocks.
- phase_i, in, NUM_CH x CNT_W: counter load value on rst/resync_i.
- en_i, in, NUM_CH: per-channel count enable; 0 freezes the counter.
- resync_i, in, 1: reload all counters from phase_i.
- irq_en_i, in, 1: interrupt generator enable.
- tick_o, out, NUM_CH: one-clock enable strobe per channel.
- level_o, out, NUM_CH: square-wave level per channel.
- irq_o, out, 1: periodic interrupt level.
- core_rst_o, out, 1: CPU reset, released on first RST_SRC tick.

## Operation
- Channel c counter cnt[c]: when en_i[c], if cnt[c] >= div_i[c] then cnt<=0 and terminal event; else cnt+1. When !en_i[c], cnt holds and no event.
- The terminal test uses >=, so lowering div_i below the current count wraps on the next enabled clock with one tick. There is no 2^CNT_W runaway.
- div_i=0: tick_o[c] high every enabled clock; level_o[c] constant 0.
- tick_o[c] <= terminal event (registered).
- level_o[c] <= (cnt[c] > div_i[c]>>1), evaluated on the current count. div=7 gives high for counts 4..7, which is a 50% duty cycle.
- resync_i: every cnt[c] <= phase_i[c]. tick_o is forced to 0 that cycle. irq state is untouched.
- Interrupt: irq_cnt is ceil(log2(IRQ_PERIOD)) bits. It advances only on the IRQ_SRC terminal event:
  - irq_o <= (irq_cnt == IRQ_AT).
  - irq_cnt wraps from IRQ_PERIOD-1 to 0.
  - irq_o is therefore high for exactly one source period out of IRQ_PERIOD.
- irq_en_i=0: irq_cnt <= 0 and irq_o <= 0 on the next clock.
- core_rst_o: set by rst. Cleared on the first RST_SRC terminal event after rst deasserts. It is never re-asserted without rst.

## Timing
- Reset (rst=1, wins over all inputs):
  - cnt[c] <= phase_i[c]; irq_cnt <= 0.
  - tick_o=0, level_o=0, irq_o=0, core_rst_o=1.
- Latency: each output is registered and is valid one clock after the counter state it decodes.
- tick_o and the downstream clk_en share an edge: consumers sample tick_o directly.
- Tick spacing: ticks are exactly div_i+1 clocks apart with en_i steady high.
- A phase_i value above div_i causes a wrap and tick on the first enabled clock after load.
- resync_i together with rst behaves as rst.
- A source terminal event in the same cycle as irq_en_i deassertion is ignored.
- Mid-operation rst: all state returns to reset values in one clock, and no partial tick is emitted.

## Structure
- Package ce_timer_pkg:
  - CNT_W default and the typedef cnt_t.
  - Default divisors for the arcade build: DIV_3MHZ=7, DIV_6MHZ=3, DIV_3KHZ=8191, DIV_6KHZ=4095.
  - IRQ defaults: 14/12.
- Sub-module ce_divider: one channel covering the counter, tick and level logic, instantiated NUM_CH times in a generate loop.
- The interrupt and core-reset logic stay in the top of this block.

## Test plan
- Divide: div_i={7,3,0,9}, phase 0, en all 1 → tick_o[0] every 8 clocks, [1] every 4, [2] every clock, [3] every 10. level_o[0] is high 4 clocks and low 4 clocks.
- Shrink: div_i[0] changed 100→5 while cnt=50 → tick on the next clock, then every 6 clocks.
- Freeze/resync:
  - en_i[1]=0 for 20 clocks → no tick_o[1], count preserved, period resumes.
  - resync_i with phase_i={0,2,4,6} → the next ticks are staggered accordingly.
- IRQ: div_i[2]=3, IRQ 14/12 → irq_o high for 4 clocks every 56 clocks, first rising 49 clocks after rst release. irq_en_i=0 → irq_o low next clock.
- Core reset: rst held 10 clocks, div_i[0]=7, phase 0 → core_rst_o falls exactly 9 clocks after rst deasserts and stays low through subsequent resync_i.
- Reset mid-count: rst asserted at cnt[0]=6 → all outputs 0 next clock and core_rst_o=1. After release, the first tick follows full div+1 spacing from the phase.
